traffic_ctrl_n: RTL and testbench
=================================

# traffic_ctrl_n

Parametrised N-way intersection light controller with per-direction demand latching, timed phases and round-robin service. It replaces the fixed two-road, sensor-hold controller in the traffic/FSM chapter designs. Each direction gets a green phase bounded by minimum and maximum dwell times, then yellow and an all-red clearance interval. Timing is counted in `tick` pulses from an external timebase, so the block runs on any clock.

## Interface
- `NUM_DIR`, 2: number of approach directions, ≥2
- `MIN_GREEN`, 3: minimum green ticks, ≥1
- `MAX_GREEN`, 6: maximum green ticks when another direction is waiting, ≥MIN_GREEN
- `YELLOW_TIME`, 2: yellow ticks, ≥1
- `ALLRED_TIME`, 1: all-red clearance ticks, ≥1
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `tick`  in  1  timebase enable; counters and transitions advance only when high
- `sensor`  in  NUM_DIR  vehicle present per direction, level
- `lights`  out  2*NUM_DIR  direction i at [2i+1:2i]; green 2'b00, yellow 2'b01, red 2'b10
- `cur_dir`  out  $clog2(NUM_DIR)  direction currently owning green/yellow
- `phase`  out  2  GREEN=0, YELLOW=1, ALLRED=2

## Operation
- Registers: `phase`, `cur_dir`, `cnt` (width $clog2(max of timing params)+1), `req[NUM_DIR]`.
- Reset: phase GREEN, cur_dir 0, cnt 0, req 0; lights = dir 0 green, all others red.
- `req[i]` is set on any cycle with `sensor[i]=1`. It is cleared on the cycle direction i is granted green, and held clear for as long as i is green. If a grant and a sensor set occur on the same cycle, the clear wins.
- `other` = |(req & ~onehot(cur_dir)).
- GREEN, on tick:
  - if `other` and ((cnt ≥ MIN_GREEN-1 and !sensor[cur_dir]) or cnt == MAX_GREEN-1): go to YELLOW, cnt←0.
  - else cnt←min(cnt+1, MAX_GREEN-1), saturating.
  - With no other demand, green holds indefinitely.
- YELLOW, on tick: if cnt == YELLOW_TIME-1, go to ALLRED with cnt←0; else cnt+1.
- ALLRED, on tick: if cnt == ALLRED_TIME-1, go to GREEN with cnt←0 and cur_dir←next; else cnt+1.
- next: the first set req bit searching cur_dir+1, cur_dir+2, … with wrap modulo NUM_DIR. If none is set, next = (cur_dir+1) mod NUM_DIR.
- `lights`: cur_dir shows green in GREEN, yellow in YELLOW, red in ALLRED. All other directions are always red. No two directions are ever non-red.
- `tick=0`: the state machine and cnt are frozen; req still latches.
- Illegal phase encoding: recover to ALLRED with cnt 0.

## Timing
- Moore outputs decoded from registered state; they change the cycle after the transition edge.
- With tick held at 1, one full handover takes exactly YELLOW_TIME + ALLRED_TIME cycles between green phases.
- The minimum green is exactly MIN_GREEN ticks.
- A sensor sample reaches req 1 cycle later, and can influence a transition from that cycle on.
- Reset mid-operation returns asynchronously to the reset state from any phase; req is discarded.

## Structure
- `traffic_pkg`: light encoding constants (GREEN/YELLOW/RED) and the `phase_t` enum.
- Sub-module `rr_pick`: combinational round-robin next-requester finder, taking `req` and `cur_dir` and producing `next`, parametrised by NUM_DIR.
- Top level holds the phase FSM, counter, req latch and light decode.

## Test plan
Parameters: NUM_DIR=4, defaults otherwise, tick=1 unless stated. Light patterns are written dir3..dir0.
- No demand after reset: `lights`=8'hA8, cur_dir=0, phase=0, held for 20 cycles.
- Handover to dir 2: sensor[2] pulsed for 1 cycle after reset, sensor[0]=0.
  - exactly 3 green cycles, then 2 cycles of 8'hA9, then 1 cycle of 8'hAA, then 8'h8A with cur_dir=2.
  - req[2] is clear after the grant.
- Max-green extension: sensor[0] held at 1, sensor[1] pulsed.
  - green lasts exactly 6 ticks, then yellow, then all-red, then dir 1 green (8'hA2).
- Round-robin wrap: cur_dir=2 green, req[0] and req[3] set.
  - next grant is dir 3 (8'h2A), then dir 0 (8'hA8).
- Tick gating: tick=0 held for 10 cycles during YELLOW.
  - phase, cnt and lights stay frozen.
  - a sensor[1] pulse still sets req[1].
- Reset mid-cycle: reset asserted during ALLRED.
  - same cycle: lights=8'hA8, cur_dir=0, req=0.
  - after release, no spurious handover.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared definitions for the N-way traffic light controller:
//             two-bit light encodings, the phase enumeration and a small
//             helper used to size the phase counter.
//  Contents : LIGHT_GREEN / LIGHT_YELLOW / LIGHT_RED, phase_t, max3()
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

   localparam logic [1:0] LIGHT_GREEN  = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_RED    = 2'b10;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2
   } phase_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_ctrl_n_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin finder. Returns the first direction
//             with a pending request, searching cur_dir+1, cur_dir+2, ...
//             with wrap-around. With no request pending it returns the
//             direction after cur_dir.
//  Ports    : req_i     [NUM_DIR-1:0]  pending requests
//             cur_dir_i [DIR_W-1:0]    current owner
//             next_o    [DIR_W-1:0]    next owner
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_DIR = 2,
   parameter int DIR_W   = $clog2(NUM_DIR)
) (
   input  logic [NUM_DIR-1:0] req_i,
   input  logic [DIR_W-1:0]   cur_dir_i,
   output logic [DIR_W-1:0]   next_o
);

   int               w_idx_int;
   logic [DIR_W-1:0] w_idx;

   // Walk the search order backwards so the last hit written is the
   // nearest requester after cur_dir.
   always_comb begin
      w_idx_int = (int'(cur_dir_i) + 1) % NUM_DIR;
      w_idx     = w_idx_int[DIR_W-1:0];
      next_o    = w_idx;
      for (int k = NUM_DIR - 1; k >= 1; k--) begin
         w_idx_int = (int'(cur_dir_i) + k) % NUM_DIR;
         w_idx     = w_idx_int[DIR_W-1:0];
         if (req_i[w_idx]) begin
            next_o = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/traffic_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_ctrl_n
//  Purpose  : N-way intersection light controller. Latches per-direction
//             demand, runs GREEN -> YELLOW -> ALLRED phases timed in tick
//             pulses, and hands green to the next requester round-robin.
//  Ports    : clk, reset (async, active-high)
//             tick            timebase enable
//             sensor  [N]     vehicle present per direction
//             lights  [2N]    per-direction light, dir i at [2i+1:2i]
//             cur_dir         direction owning green/yellow
//             phase   [2]     0 GREEN, 1 YELLOW, 2 ALLRED
//  Revision : 1.0  initial release
// ============================================================================
module traffic_ctrl_n
   import traffic_pkg::*;
#(
   parameter int NUM_DIR     = 2,
   parameter int MIN_GREEN   = 3,
   parameter int MAX_GREEN   = 6,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tick,
   input  logic [NUM_DIR-1:0]           sensor,
   output logic [2*NUM_DIR-1:0]         lights,
   output logic [$clog2(NUM_DIR)-1:0]   cur_dir,
   output logic [1:0]                   phase
);

   localparam int DIR_W = $clog2(NUM_DIR);
   localparam int CNT_W = $clog2(max3(MAX_GREEN, YELLOW_TIME, ALLRED_TIME)) + 1;

   localparam logic [1:0] S_GREEN  = PH_GREEN;
   localparam logic [1:0] S_YELLOW = PH_YELLOW;
   localparam logic [1:0] S_ALLRED = PH_ALLRED;

   localparam logic [CNT_W-1:0] MING_M1 = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAXG_M1 = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] ARED_M1 = CNT_W'(ALLRED_TIME - 1);
   localparam logic [NUM_DIR-1:0] ONE_DIR = {{(NUM_DIR-1){1'b0}}, 1'b1};

   logic [1:0]         phase_q,   phase_d;
   logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [NUM_DIR-1:0] req_q,     req_d;

   logic [DIR_W-1:0]   w_next;
   logic [NUM_DIR-1:0] w_cur_mask;
   logic [NUM_DIR-1:0] w_clr_mask;
   logic               w_other;
   logic               w_grant;
   logic [1:0]         w_cur_light;

   rr_pick #(
      .NUM_DIR (NUM_DIR),
      .DIR_W   (DIR_W)
   ) u_rr_pick (
      .req_i     (req_q),
      .cur_dir_i (cur_dir_q),
      .next_o    (w_next)
   );

   assign w_cur_mask = ONE_DIR << cur_dir_q;
   assign w_other    = |(req_q & ~w_cur_mask);

   // Phase FSM and counter; advances only on tick, except that an illegal
   // phase encoding recovers immediately.
   always_comb begin
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      cur_dir_d = cur_dir_q;
      w_grant   = 1'b0;
      case (phase_q)
         S_GREEN: begin
            if (tick) begin
               if (w_other && (((cnt_q >= MING_M1) && !sensor[cur_dir_q]) ||
                               (cnt_q == MAXG_M1))) begin
                  phase_d = S_YELLOW;
                  cnt_d   = '0;
               end else if (cnt_q < MAXG_M1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_YELLOW: begin
            if (tick) begin
               if (cnt_q == YEL_M1) begin
                  phase_d = S_ALLRED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_ALLRED: begin
            if (tick) begin
               if (cnt_q == ARED_M1) begin
                  phase_d   = S_GREEN;
                  cnt_d     = '0;
                  cur_dir_d = w_next;
                  w_grant   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            phase_d = S_ALLRED;
            cnt_d   = '0;
         end
      endcase
   end

   // The granted direction is cleared on the grant edge and kept clear for
   // as long as it is green; a clear overrides a simultaneous sensor set.
   always_comb begin
      w_clr_mask = '0;
      if (w_grant) begin
         w_clr_mask = ONE_DIR << w_next;
      end else if (phase_q == S_GREEN) begin
         w_clr_mask = w_cur_mask;
      end
      req_d = (req_q | sensor) & ~w_clr_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q   <= S_GREEN;
         cur_dir_q <= '0;
         cnt_q     <= '0;
         req_q     <= '0;
      end else begin
         phase_q   <= phase_d;
         cur_dir_q <= cur_dir_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
      end
   end

   always_comb begin
      case (phase_q)
         S_GREEN:  w_cur_light = LIGHT_GREEN;
         S_YELLOW: w_cur_light = LIGHT_YELLOW;
         default:  w_cur_light = LIGHT_RED;
      endcase
   end

   for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_light
      assign lights[2*gi+1 -: 2] = (cur_dir_q == DIR_W'(gi)) ? w_cur_light : LIGHT_RED;
   end

   assign cur_dir = cur_dir_q;
   assign phase   = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_ctrl_n
//  Purpose  : Directed self-checking bench for traffic_ctrl_n, four
//             directions, default timing. Light patterns are dir3..dir0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_ctrl_n;

   localparam int N = 4;

   logic           clk    = 1'b0;
   logic           reset  = 1'b1;
   logic           tick   = 1'b1;
   logic [N-1:0]   sensor = '0;
   logic [2*N-1:0] lights;
   logic [1:0]     cur_dir;
   logic [1:0]     phase;

   int n_chk  = 0;
   int n_pass = 0;

   traffic_ctrl_n #(
      .NUM_DIR     (N),
      .MIN_GREEN   (3),
      .MAX_GREEN   (6),
      .YELLOW_TIME (2),
      .ALLRED_TIME (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .sensor  (sensor),
      .lights  (lights),
      .cur_dir (cur_dir),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      sensor = '0;
      tick   = 1'b1;
      step();
      step();
      reset  = 1'b0;
   endtask

   // Checks lights on consecutive cycles; sensor takes after_sensor once the
   // first edge has passed.
   task automatic run_seq(input string tag, input int len,
                          input logic [7:0] seq [16], input logic [N-1:0] after_sensor);
      for (int i = 0; i < len; i++) begin
         if (i > 0) begin
            step();
            sensor = after_sensor;
         end
         chk($sformatf("%s_%0d", tag, i), {24'd0, lights}, {24'd0, seq[i]});
      end
   endtask

   initial begin
      // No demand: dir0 green forever
      do_reset();
      chk("rst_lights", {24'd0, lights}, 32'hA8);
      chk("rst_req", {28'd0, dut.req_q}, 32'h0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("idle_%0d", i), {24'd0, lights}, 32'hA8);
      end
      chk("idle_dir", {30'd0, cur_dir}, 32'd0);
      chk("idle_phase", {30'd0, phase}, 32'd0);

      // Handover to dir 2, then round-robin wrap 3 -> 0
      do_reset();
      sensor = 4'b0100;
      run_seq("ho2", 7, '{8'hA8, 8'hA8, 8'hA8, 8'hA9, 8'hA9, 8'hAA, 8'h8A,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              4'b0000);
      chk("ho2_dir", {30'd0, cur_dir}, 32'd2);
      chk("ho2_req2", {31'd0, dut.req_q[2]}, 32'd0);
      sensor = 4'b1001;
      run_seq("wrap", 13, '{8'h8A, 8'h8A, 8'h8A, 8'h9A, 8'h9A, 8'hAA, 8'h2A,
                            8'h2A, 8'h2A, 8'h6A, 8'h6A, 8'hAA, 8'hA8, 8'h00, 8'h00, 8'h00},
              4'b0000);
      chk("wrap_dir", {30'd0, cur_dir}, 32'd0);

      // Max-green extension: sensor[0] held, sensor[1] pulsed
      do_reset();
      sensor = 4'b0011;
      run_seq("maxg", 10, '{8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'hA8, 8'hA9,
                            8'hA9, 8'hAA, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              4'b0001);
      chk("maxg_dir", {30'd0, cur_dir}, 32'd1);

      // Tick gating during YELLOW
      do_reset();
      sensor = 4'b0100;
      run_seq("tg_pre", 4, '{8'hA9 ^ 8'h01, 8'hA8, 8'hA8, 8'hA9, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              4'b0000);
      tick = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sensor = (i == 2) ? 4'b0010 : 4'b0000;
         step();
         chk($sformatf("tg_lights_%0d", i), {24'd0, lights}, 32'hA9);
         chk($sformatf("tg_phase_%0d", i), {30'd0, phase}, 32'd1);
      end
      sensor = '0;
      chk("tg_cnt", {28'd0, dut.cnt_q}, 32'd0);
      chk("tg_req1", {31'd0, dut.req_q[1]}, 32'd1);
      tick = 1'b1;
      run_seq("tg_post", 4, '{8'hA9, 8'hA9, 8'hAA, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              4'b0000);
      chk("tg_dir", {30'd0, cur_dir}, 32'd1);

      // Asynchronous reset during ALLRED
      do_reset();
      sensor = 4'b0100;
      run_seq("ar_pre", 6, '{8'hA8, 8'hA8, 8'hA8, 8'hA9, 8'hA9, 8'hAA, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              4'b0000);
      chk("ar_req_before", {28'd0, dut.req_q}, 32'h4);
      #2 reset = 1'b1;
      #1;
      chk("ar_lights", {24'd0, lights}, 32'hA8);
      chk("ar_dir", {30'd0, cur_dir}, 32'd0);
      chk("ar_phase", {30'd0, phase}, 32'd0);
      chk("ar_req", {28'd0, dut.req_q}, 32'h0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("ar_hold_%0d", i), {24'd0, lights}, 32'hA8);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
